ml_demod_scheduler: RTL and testbench

//  Job scheduler and output sequencer for the ML demodulator core.
//  - Queues incoming vector jobs (y_hat, R) and starts the core one job at a time.
//  - Collects each 8-LLR result and streams it out byte-serially on a valid/ready handshake.
//  - Never starts a job unless result buffer space is reserved, so output backpressure
//    (i_rd_rdy low for 512+ cycles) never loses data.

---
 rtl/ml_demod_pkg.sv | 21 ++
 rtl/ml_sched_fifo.sv | 53 +++++
 rtl/ml_demod_scheduler.sv | 137 +++++++++++++
 tb/tb_ml_demod_scheduler.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ml_demod_pkg.sv
// Shared widths, job record and core FSM states for the ML demodulator scheduler.
package ml_demod_pkg;

  localparam int Y_HAT_W = 160;
  localparam int R_W     = 320;
  localparam int LLR_W   = 8;
  localparam int N_LLR   = 8;
  localparam int RES_W   = LLR_W * N_LLR;

  typedef struct packed {
    logic [Y_HAT_W-1:0] y_hat;
    logic [R_W-1:0]     r;
  } job_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } core_state_e;

endpackage

// File: rtl/ml_sched_fifo.sv
// Synchronous show-ahead FIFO; head is visible on o_rd_dat while not empty.
// A write when full is accepted only if a read happens on the same edge.
module ml_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_vld,
  output logic [WIDTH-1:0] o_rd_dat,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_wr;
  logic             do_rd;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty  = (count == '0);
  assign o_full   = (count == CW'(DEPTH));
  assign do_rd    = i_rd_vld && !o_empty;
  assign do_wr    = i_wr_vld && (!o_full || do_rd);
  assign o_rd_dat = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_wr) mem[wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/ml_demod_scheduler.sv
// Job queue, credit-gated core launcher and byte-serial LLR output for the ML demodulator.
// Define LLR_NONZERO_EN to remap zero LLR bytes to 8'h01 on the output.
module ml_demod_scheduler
  import ml_demod_pkg::*;
#(
  parameter int JOB_DEPTH = 4,
  parameter int RES_DEPTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_trig,
  input  logic [Y_HAT_W-1:0] i_y_hat,
  input  logic [R_W-1:0]     i_r,
  output logic               o_core_start,
  output logic [Y_HAT_W-1:0] o_core_y_hat,
  output logic [R_W-1:0]     o_core_r,
  input  logic               i_core_done,
  input  logic [RES_W-1:0]   i_core_llr,
  output logic               o_rd_vld,
  input  logic               i_rd_rdy,
  output logic [LLR_W-1:0]   o_llr,
  output logic               o_hard_bit,
  output logic               o_overflow,
  output logic               o_busy
);

  localparam int CRW = $clog2(RES_DEPTH + 1);
  localparam int BIW = $clog2(N_LLR);

  core_state_e      state;
  core_state_e      state_nxt;
  job_t             job_in;
  job_t             job_head;
  logic             job_empty;
  logic             job_full;
  logic             job_pop;
  logic [RES_W-1:0] res_head;
  logic             res_empty;
  logic             res_full;
  logic             res_push;
  logic [CRW-1:0]   credits;
  logic [BIW-1:0]   byte_idx;
  logic             rd_hs;
  logic             last_hs;
  logic             can_start;
  logic [LLR_W-1:0] llr_raw;
  logic [LLR_W-1:0] llr_fix;

  assign job_in = '{y_hat: i_y_hat, r: i_r};

  ml_sched_fifo #(.WIDTH($bits(job_t)), .DEPTH(JOB_DEPTH)) u_job_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_vld (i_trig),
    .i_wr_dat (job_in),
    .i_rd_vld (job_pop),
    .o_rd_dat (job_head),
    .o_empty  (job_empty),
    .o_full   (job_full)
  );

  ml_sched_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr_vld (res_push),
    .i_wr_dat (i_core_llr),
    .i_rd_vld (last_hs),
    .o_rd_dat (res_head),
    .o_empty  (res_empty),
    .o_full   (res_full)
  );

  assign rd_hs     = o_rd_vld && i_rd_rdy;
  assign last_hs   = rd_hs && (byte_idx == BIW'(N_LLR - 1));
  // A slot freed by the final byte can be re-reserved on the same edge.
  assign can_start = (credits != '0) || last_hs;
  assign res_push  = (state == ST_WAIT) && i_core_done;

  always_comb begin
    state_nxt    = state;
    job_pop      = 1'b0;
    o_core_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!job_empty && can_start) begin
          job_pop   = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        o_core_start = 1'b1;
        state_nxt    = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_core_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      o_core_y_hat <= '0;
      o_core_r     <= '0;
      credits      <= CRW'(RES_DEPTH);
      byte_idx     <= '0;
      o_overflow   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (job_pop) begin
        o_core_y_hat <= job_head.y_hat;
        o_core_r     <= job_head.r;
      end
      credits <= credits + CRW'(last_hs) - CRW'(job_pop);
      if (rd_hs) byte_idx <= byte_idx + BIW'(1);
      if (i_trig && job_full && !job_pop) o_overflow <= 1'b1;
    end
  end

  assign llr_raw = res_head[byte_idx*LLR_W +: LLR_W];

`ifdef LLR_NONZERO_EN
  assign llr_fix = (llr_raw == '0) ? LLR_W'(1) : llr_raw;
`else
  assign llr_fix = llr_raw;
`endif

  assign o_rd_vld   = !res_empty;
  assign o_llr      = res_empty ? '0 : llr_fix;
  assign o_hard_bit = o_llr[LLR_W-1];
  assign o_busy     = !job_empty || (state != ST_IDLE) || !res_empty;

  // Credit reservation must make this unreachable.
  res_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset) !(res_push && res_full));

endmodule

// File: tb/tb_ml_demod_scheduler.sv
// Randomized scenario bench for ml_demod_scheduler with a queue-based scoreboard.
`timescale 1ns/1ps
module tb_ml_demod_scheduler;
  import ml_demod_pkg::*;

  localparam int JOB_DEPTH = 4;
  localparam int RES_DEPTH = 2;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_trig;
  logic [Y_HAT_W-1:0] i_y_hat;
  logic [R_W-1:0]     i_r;
  logic               o_core_start;
  logic [Y_HAT_W-1:0] o_core_y_hat;
  logic [R_W-1:0]     o_core_r;
  logic               i_core_done;
  logic [RES_W-1:0]   i_core_llr;
  logic               o_rd_vld;
  logic               i_rd_rdy;
  logic [LLR_W-1:0]   o_llr;
  logic               o_hard_bit;
  logic               o_overflow;
  logic               o_busy;

  ml_demod_scheduler #(.JOB_DEPTH(JOB_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_trig(i_trig), .i_y_hat(i_y_hat), .i_r(i_r),
    .o_core_start(o_core_start), .o_core_y_hat(o_core_y_hat), .o_core_r(o_core_r),
    .i_core_done(i_core_done), .i_core_llr(i_core_llr), .o_rd_vld(o_rd_vld),
    .i_rd_rdy(i_rd_rdy), .o_llr(o_llr), .o_hard_bit(o_hard_bit),
    .o_overflow(o_overflow), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard state
  job_t        exp_jobs[$];
  job_t        start_jobs[$];
  int          start_cycs[$];
  logic [63:0] sent_llr[$];
  int          done_cycs[$];
  logic [7:0]  got_llr[$];
  logic        got_hb[$];
  int          got_cyc[$];
  int          hold_err, gap_err, first_vld_cyc, vec_pos;
  logic        prev_stall;
  logic [7:0]  prev_llr;

  int          core_lat   = 10;
  bit          core_stall = 1'b0;
  bit          use_forced = 1'b0;
  logic [63:0] forced_llr = 64'h0;

  function automatic job_t rand_job();
    logic [$bits(job_t)-1:0] v;
    for (int i = 0; i < $bits(job_t); i += 32) v[i +: 32] = $urandom;
    return job_t'(v);
  endfunction

  function automatic logic [7:0] model_llr(input logic [63:0] v, input int k);
    logic [7:0] b;
    b = v[8*k +: 8];
`ifdef LLR_NONZERO_EN
    if (b == 8'h00) b = 8'h01;
`endif
    return b;
  endfunction

  task automatic clear_model();
    exp_jobs.delete(); start_jobs.delete(); start_cycs.delete();
    sent_llr.delete(); done_cycs.delete();
    got_llr.delete(); got_hb.delete(); got_cyc.delete();
    hold_err = 0; gap_err = 0; first_vld_cyc = -1;
  endtask

  // Behavioural core: answers each start after core_lat cycles with an LLR vector.
  initial begin
    int n;
    i_core_done = 1'b0;
    i_core_llr  = '0;
    forever begin
      @(negedge i_clk);
      if (o_core_start === 1'b1 && !i_reset) begin
        start_jobs.push_back(job_t'({o_core_y_hat, o_core_r}));
        start_cycs.push_back(cyc);
        n = 0;
        while ((n < core_lat || core_stall) && !i_reset) begin
          @(negedge i_clk);
          n++;
        end
        if (!i_reset) begin
          i_core_llr  = use_forced ? forced_llr : {$urandom, $urandom};
          i_core_done = 1'b1;
          sent_llr.push_back(i_core_llr);
          done_cycs.push_back(cyc);
          @(negedge i_clk);
          i_core_done = 1'b0;
        end
      end
    end
  end

  // Output monitor: records transfers, hold violations and in-vector gaps.
  initial begin
    prev_stall = 1'b0; prev_llr = '0; vec_pos = 0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        prev_stall = 1'b0;
        vec_pos    = 0;
      end else begin
        if (prev_stall && (o_rd_vld !== 1'b1 || o_llr !== prev_llr)) hold_err++;
        if (i_rd_rdy && !o_rd_vld && vec_pos != 0) gap_err++;
        if (o_rd_vld && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (o_rd_vld && i_rd_rdy) begin
          got_llr.push_back(o_llr); got_hb.push_back(o_hard_bit); got_cyc.push_back(cyc);
          vec_pos = (vec_pos + 1) % 8;
        end
        prev_stall = o_rd_vld && !i_rd_rdy;
        prev_llr   = o_llr;
      end
    end
  end

  task automatic send_job(input job_t j, output int t);
    @(posedge i_clk); #1;
    i_trig = 1'b1; i_y_hat = j.y_hat; i_r = j.r; t = cyc;
    exp_jobs.push_back(j);
    @(posedge i_clk); #1;
    i_trig = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    for (int i = 0; i < budget && got_llr.size() < n; i++) @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge i_clk); #1;
    i_reset = 1'b1; i_trig = 1'b0; i_rd_rdy = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_trig = 1'b0; i_rd_rdy = 1'b0; i_y_hat = '0; i_r = '0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_checks++;
    if ({o_core_start, o_rd_vld, o_llr, o_hard_bit, o_overflow, o_busy} !== 13'h0)
      $display("FAIL reset_ctrl: got %0h expected 0", {o_core_start, o_rd_vld, o_llr, o_hard_bit, o_overflow, o_busy});
    else n_pass++;
    n_checks++;
    if ({o_core_y_hat, o_core_r} !== '0) $display("FAIL reset_job_regs: got %0h expected 0", {o_core_y_hat, o_core_r});
    else n_pass++;
    @(posedge i_clk); #1 i_reset = 1'b0;
    clear_model();
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_busy, o_rd_vld, o_core_start} !== 3'b000) $display("FAIL idle_after_reset: got %b expected 000", {o_busy, o_rd_vld, o_core_start});
    else n_pass++;
  endtask

  task automatic test_single();
    job_t j; int t; bit ok;
    clear_model();
    core_lat = 10; i_rd_rdy = 1'b1;
    j = rand_job();
    send_job(j, t);
    wait_bytes(8, 100);
    n_checks++;
    if (start_jobs.size() != 1 || got_llr.size() != 8)
      $display("FAIL single_counts: got starts=%0d bytes=%0d expected 1/8", start_jobs.size(), got_llr.size());
    else begin
      n_pass++;
      n_checks++;
      if (start_jobs[0] !== j) $display("FAIL single_job_data: got %0h expected %0h", start_jobs[0], j);
      else n_pass++;
      n_checks++;
      if (start_cycs[0] != t + 2) $display("FAIL single_start_latency: got %0d expected %0d", start_cycs[0] - t, 2);
      else n_pass++;
      n_checks++;
      if (first_vld_cyc != done_cycs[0] + 1) $display("FAIL single_vld_rise: got %0d expected %0d", first_vld_cyc, done_cycs[0] + 1);
      else n_pass++;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) if (got_cyc[i] != done_cycs[0] + 1 + i) ok = 1'b0;
      n_checks++;
      if (!ok) $display("FAIL single_consecutive: got first=%0d last=%0d expected %0d..%0d", got_cyc[0], got_cyc[7], done_cycs[0] + 1, done_cycs[0] + 8);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if ({got_hb[i], got_llr[i]} !== {model_llr(sent_llr[0], i) >> 7, model_llr(sent_llr[0], i)})
          $display("FAIL single_byte%0d: got %0h/%b expected %0h", i, got_llr[i], got_hb[i], model_llr(sent_llr[0], i));
        else n_pass++;
      end
    end
    repeat (3) @(negedge i_clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL single_busy_clear: got %b expected 0", o_busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    job_t j; int t;
    clear_model();
    core_lat = 20; i_rd_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin j = rand_job(); send_job(j, t); end
    repeat (600) @(posedge i_clk);
    #1;
    n_checks++;
    if (start_jobs.size() != RES_DEPTH) $display("FAIL bp_starts_blocked: got %0d expected %0d", start_jobs.size(), RES_DEPTH);
    else n_pass++;
    n_checks++;
    if (o_rd_vld !== 1'b1 || hold_err != 0) $display("FAIL bp_vld_held: got vld=%b hold_err=%0d expected 1/0", o_rd_vld, hold_err);
    else n_pass++;
    i_rd_rdy = 1'b1;
    wait_bytes(32, 600);
    n_checks++;
    if (start_jobs.size() != 4 || got_llr.size() != 32 || sent_llr.size() != 4)
      $display("FAIL bp_counts: got starts=%0d bytes=%0d expected 4/32", start_jobs.size(), got_llr.size());
    else begin
      n_pass++;
      n_checks++;
      if (start_cycs[2] <= got_cyc[7]) $display("FAIL bp_start_after_drain: got %0d expected > %0d", start_cycs[2], got_cyc[7]);
      else n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (start_jobs[k] !== exp_jobs[k]) $display("FAIL bp_job%0d: got %0h expected %0h", k, start_jobs[k], exp_jobs[k]);
        else n_pass++;
      end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (got_llr[i] !== model_llr(sent_llr[i/8], i%8)) $display("FAIL bp_byte%0d: got %0h expected %0h", i, got_llr[i], model_llr(sent_llr[i/8], i%8));
        else n_pass++;
      end
    end
    n_checks++;
    if (hold_err != 0 || gap_err != 0 || o_overflow !== 1'b0)
      $display("FAIL bp_stream_integrity: got hold=%0d gap=%0d ovf=%b expected 0/0/0", hold_err, gap_err, o_overflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    job_t jobs[6];
    clear_model();
    core_lat = 5; core_stall = 1'b1; i_rd_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      jobs[k] = rand_job();
      @(posedge i_clk); #1;
      i_trig = 1'b1; i_y_hat = jobs[k].y_hat; i_r = jobs[k].r;
      if (k < JOB_DEPTH + 1) exp_jobs.push_back(jobs[k]);
    end
    @(posedge i_clk); #1 i_trig = 1'b0;
    repeat (5) @(negedge i_clk);
    n_checks++;
    if ({o_overflow, o_busy} !== 2'b11) $display("FAIL ovf_set: got ovf/busy=%b expected 11", {o_overflow, o_busy});
    else n_pass++;
    core_stall = 1'b0;
    wait_bytes(8 * (JOB_DEPTH + 1), 1000);
    repeat (40) @(posedge i_clk);
    #1;
    n_checks++;
    if (start_jobs.size() != JOB_DEPTH + 1 || got_llr.size() != 8 * (JOB_DEPTH + 1))
      $display("FAIL ovf_accepted: got starts=%0d bytes=%0d expected %0d/%0d", start_jobs.size(), got_llr.size(), JOB_DEPTH + 1, 8 * (JOB_DEPTH + 1));
    else begin
      n_pass++;
      for (int k = 0; k < JOB_DEPTH + 1; k++) begin
        n_checks++;
        if (start_jobs[k] !== exp_jobs[k]) $display("FAIL ovf_job%0d: got %0h expected %0h", k, start_jobs[k], exp_jobs[k]);
        else n_pass++;
      end
      for (int i = 0; i < 8 * (JOB_DEPTH + 1); i++) begin
        n_checks++;
        if (got_llr[i] !== model_llr(sent_llr[i/8], i%8)) $display("FAIL ovf_byte%0d: got %0h expected %0h", i, got_llr[i], model_llr(sent_llr[i/8], i%8));
        else n_pass++;
      end
    end
    n_checks++;
    if (o_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", o_overflow);
    else n_pass++;
    apply_reset();
    n_checks++;
    if (o_overflow !== 1'b0) $display("FAIL ovf_cleared_by_reset: got %b expected 0", o_overflow);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    job_t j; int t;
    clear_model();
    core_lat = 3; i_rd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin j = rand_job(); send_job(j, t); end
    repeat (60) @(posedge i_clk);
    #1;
    n_checks++;
    if (start_jobs.size() != 2 || o_busy !== 1'b1) $display("FAIL sim_credit_stall: got starts=%0d busy=%b expected 2/1", start_jobs.size(), o_busy);
    else n_pass++;
    i_rd_rdy = 1'b1;
    wait_bytes(24, 300);
    n_checks++;
    if (start_jobs.size() != 3 || got_llr.size() != 24) $display("FAIL sim_counts: got starts=%0d bytes=%0d expected 3/24", start_jobs.size(), got_llr.size());
    else begin
      n_pass++;
      n_checks++;
      if (start_cycs[2] != got_cyc[7] + 1) $display("FAIL sim_start_on_last_byte: got %0d expected %0d", start_cycs[2], got_cyc[7] + 1);
      else n_pass++;
    end
    // Credit net must be back to RES_DEPTH: exactly two more starts under full backpressure.
    i_rd_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin j = rand_job(); send_job(j, t); end
    repeat (60) @(posedge i_clk);
    #1;
    n_checks++;
    if (start_jobs.size() != 3 + RES_DEPTH) $display("FAIL sim_credit_restore: got %0d expected %0d", start_jobs.size(), 3 + RES_DEPTH);
    else n_pass++;
    i_rd_rdy = 1'b1;
    wait_bytes(48, 400);
    n_checks++;
    if (start_jobs.size() != 6 || got_llr.size() != 48) $display("FAIL sim_total: got starts=%0d bytes=%0d expected 6/48", start_jobs.size(), got_llr.size());
    else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (start_jobs[k] !== exp_jobs[k]) $display("FAIL sim_job%0d: got %0h expected %0h", k, start_jobs[k], exp_jobs[k]);
        else n_pass++;
      end
      for (int i = 0; i < 48; i++) begin
        n_checks++;
        if (got_llr[i] !== model_llr(sent_llr[i/8], i%8)) $display("FAIL sim_byte%0d: got %0h expected %0h", i, got_llr[i], model_llr(sent_llr[i/8], i%8));
        else n_pass++;
      end
    end
    n_checks++;
    if (gap_err != 0 || hold_err != 0) $display("FAIL sim_no_gaps: got gap=%0d hold=%0d expected 0/0", gap_err, hold_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    job_t j; int t; logic [63:0] v;
    clear_model();
    core_lat = 4; i_rd_rdy = 1'b0;
    j = rand_job(); send_job(j, t);
    repeat (30) @(posedge i_clk);
    #1 i_rd_rdy = 1'b1;
    repeat (4) @(posedge i_clk);
    #1 i_rd_rdy = 1'b0;
    n_checks++;
    if (got_llr.size() != 4 || sent_llr.size() != 1) $display("FAIL mid_partial: got %0d bytes expected 4", got_llr.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_llr[3] !== model_llr(sent_llr[0], 3)) $display("FAIL mid_byte3: got %0h expected %0h", got_llr[3], model_llr(sent_llr[0], 3));
      else n_pass++;
    end
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if ({o_busy, o_rd_vld, o_llr, o_hard_bit, o_core_start, o_overflow} !== 13'h0)
      $display("FAIL mid_reset_outputs: got %0h expected 0", {o_busy, o_rd_vld, o_llr, o_hard_bit, o_core_start, o_overflow});
    else n_pass++;
    n_checks++;
    if ({o_core_y_hat, o_core_r} !== '0) $display("FAIL mid_reset_job_regs: got %0h expected 0", {o_core_y_hat, o_core_r});
    else n_pass++;
    @(posedge i_clk); #1 i_reset = 1'b0;
    clear_model();
    i_rd_rdy = 1'b1;
    j = rand_job(); send_job(j, t);
    wait_bytes(8, 100);
    n_checks++;
    if (got_llr.size() != 8 || sent_llr.size() != 1) $display("FAIL mid_new_job: got %0d bytes expected 8", got_llr.size());
    else begin
      n_pass++;
      v = sent_llr[0];
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (got_llr[i] !== model_llr(v, i)) $display("FAIL mid_new_byte%0d: got %0h expected %0h", i, got_llr[i], model_llr(v, i));
        else n_pass++;
      end
    end
  endtask

  task automatic test_llr_table();
    job_t j; int t;
    logic [7:0] tbl [8];
    tbl = '{8'h81, 8'h01, 8'h00, 8'h7F, 8'h80, 8'h00, 8'hFF, 8'h00};
`ifdef LLR_NONZERO_EN
    for (int i = 0; i < 8; i++) if (tbl[i] == 8'h00) tbl[i] = 8'h01;
`endif
    clear_model();
    core_lat = 2; i_rd_rdy = 1'b1;
    use_forced = 1'b1; forced_llr = 64'h00FF_0080_7F00_0181;
    j = rand_job(); send_job(j, t);
    wait_bytes(8, 100);
    use_forced = 1'b0;
    n_checks++;
    if (got_llr.size() != 8) $display("FAIL table_count: got %0d expected 8", got_llr.size());
    else begin
      n_pass++;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if ({got_hb[i], got_llr[i]} !== {tbl[i][7], tbl[i]})
          $display("FAIL table_byte%0d: got %0h/%b expected %0h/%b", i, got_llr[i], got_hb[i], tbl[i], tbl[i][7]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_stream();
    job_t j; int sent;
    clear_model();
    sent = 0;
    for (int c = 0; c < 3000 && sent < 8; c++) begin
      @(posedge i_clk); #1;
      i_rd_rdy = ($urandom_range(0, 3) != 0);
      core_lat = $urandom_range(1, 12);
      if (i_trig) i_trig = 1'b0;
      else if ($urandom_range(0, 5) == 0 && (sent - start_jobs.size()) < JOB_DEPTH) begin
        j = rand_job();
        exp_jobs.push_back(j);
        i_trig = 1'b1; i_y_hat = j.y_hat; i_r = j.r;
        sent++;
      end
    end
    @(posedge i_clk); #1;
    i_trig = 1'b0; i_rd_rdy = 1'b1;
    wait_bytes(8 * sent, 1000);
    n_checks++;
    if (sent != 8 || start_jobs.size() != sent || got_llr.size() != 8 * sent || sent_llr.size() != sent)
      $display("FAIL rand_counts: got sent=%0d starts=%0d bytes=%0d expected 8/8/64", sent, start_jobs.size(), got_llr.size());
    else begin
      n_pass++;
      for (int k = 0; k < sent; k++) begin
        n_checks++;
        if (start_jobs[k] !== exp_jobs[k]) $display("FAIL rand_job%0d: got %0h expected %0h", k, start_jobs[k], exp_jobs[k]);
        else n_pass++;
      end
      for (int i = 0; i < 8 * sent; i++) begin
        n_checks++;
        if ({got_hb[i], got_llr[i]} !== {model_llr(sent_llr[i/8], i%8) >> 7, model_llr(sent_llr[i/8], i%8)})
          $display("FAIL rand_byte%0d: got %0h expected %0h", i, got_llr[i], model_llr(sent_llr[i/8], i%8));
        else n_pass++;
      end
    end
    n_checks++;
    if (hold_err != 0 || gap_err != 0 || o_overflow !== 1'b0)
      $display("FAIL rand_integrity: got hold=%0d gap=%0d ovf=%b expected 0/0/0", hold_err, gap_err, o_overflow);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    i_trig = 1'b0; i_rd_rdy = 1'b0; i_y_hat = '0; i_r = '0; i_reset = 1'b1;
    clear_model();
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    test_llr_table();
    test_random_stream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
